sram_1r1w_init: RTL and testbench
=================================

Name: sram_1r1w_init

Overview:
- Parametrised successor of the single-port SoC SRAM model.
- Separate read and write ports, both usable in the same cycle.
- Byte strobes, write-first forwarding on a same-address collision, and a selectable 1- or 2-cycle read latency.
- A hardware initialisation engine fills the array with a constant after reset or on request.
- Sits behind the TCM/cache bus adapters; replaces direct instances of the old model in simulation builds.

Parameters:
- DATA_W, 32: data width in bits; must be a multiple of 8.
- ADDR_W, 14: word address width; DEPTH = 2**ADDR_W.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- INIT_ON_RESET, 1: 1 starts the fill automatically after rstn deassertion.
- INIT_VAL, 0: DATA_W-bit fill pattern.

Ports:
- clk, input, 1: clock, rising edge.
- rstn, input, 1: reset, asynchronous, active-low.
- init_req, input, 1: single-cycle pulse; starts a fill when idle.
- busy, output, 1: high while the fill is running.
- wcs, input, 1: write request.
- wa, input, ADDR_W: write word address.
- wbyte, input, DATA_W/8: byte write strobes.
- wdi, input, DATA_W: write data.
- rcs, input, 1: read request.
- ra, input, ADDR_W: read word address.
- rdo, output, DATA_W: read data.
- rvalid, output, 1: rdo carries fresh data this cycle.

Behaviour:
- Reset (rstn low, asynchronous):
  - rdo = 0 and rvalid = 0.
  - Internal OUT_REG stage = 0, valid = 0.
  - busy = INIT_ON_RESET.
  - fill counter = 0.
  - FSM = INIT if INIT_ON_RESET, otherwise IDLE.
  - Array contents are not reset.
- FSM states: IDLE and INIT.
  - IDLE -> INIT on init_req = 1. The counter is cleared, and busy rises the next cycle.
  - INIT: each cycle, mem[cnt] <= INIT_VAL and cnt increments.
  - At cnt = DEPTH-1 the write completes, FSM returns to IDLE, and busy falls the following cycle.
  - A fill takes exactly DEPTH cycles with busy high.
  - init_req during INIT is ignored; there is no restart.
- While busy, wcs and rcs are ignored: no array write, rvalid = 0, rdo holds.
- In IDLE, init_req has priority over a same-cycle wcs/rcs; that access is dropped.
- Write: on an edge with wcs = 1 and FSM in IDLE, each byte i with wbyte[i] = 1 is updated from wdi[8i+7:8i]. Other bytes are unchanged. wcs with wbyte = 0 is a no-op.
- Read: on an edge with rcs = 1 and FSM in IDLE, the array is sampled.
  - OUT_REG = 0: rdo and rvalid = 1 are presented the cycle after the rcs edge.
  - OUT_REG = 1: rdo and rvalid = 1 are presented two cycles after the rcs edge.
  - rvalid is a one-cycle pulse per accepted read.
  - Back-to-back reads are fully pipelined, one per cycle.
- rdo holds its last value when no read returns; it never goes X.
- Same-cycle read and write to the same address: write-first. Returned bytes take wdi where wbyte is set and old array bytes elsewhere.
- Same-cycle read and write to different addresses: independent.
- A read issued one cycle after a write to the same address returns the written data.
- Reset asserted mid-fill aborts it. With INIT_ON_RESET = 1 the fill restarts from address 0 after release; otherwise the FSM stays IDLE with a partially filled array.
- Address wrap: the array is full power-of-two depth, so every address is legal. The fill counter is ADDR_W+1 bits or compares against DEPTH-1; it must not wrap early.
- A read in flight when init_req is accepted still returns, with the pre-fill data.

Test Plan (ADDR_W = 4, DATA_W = 32, INIT_VAL = 32'hA5A5_A5A5 unless stated):
1. Reset release, INIT_ON_RESET = 1 -> busy high for exactly 16 cycles. Then reading addresses 0..15 returns A5A5_A5A5 each, with rvalid one cycle after each rcs.
2. Write wa = 3, wdi = 1122_3344, wbyte = 4'b0101 over the fill pattern, then read address 3 -> rdo = A522_A544. Repeat with OUT_REG = 1 -> the same value two cycles after rcs.
3. Same-cycle wcs/rcs to address 7: wdi = DEAD_BEEF, wbyte = 4'b1100 -> rdo = DEAD_A5A5. A concurrent write to address 8 with a read of address 9 -> rdo = A5A5_A5A5.
4. Pulse init_req together with wcs to address 1 (wdi = 0) -> the write is dropped and busy is high for 16 cycles. A read of address 1 afterwards returns A5A5_A5A5. rcs during busy gives rvalid = 0 and rdo unchanged.
5. Assert rstn low at fill cycle 5, release 3 cycles later -> busy = 1 immediately. The fill restarts at address 0 and runs 16 full cycles; rdo = 0 and rvalid = 0 throughout reset.
6. Sixteen back-to-back reads, addresses 0..15, after writing mem[i] = i -> rvalid high for 16 consecutive cycles with rdo = 0, 1, ..., 15 in order (OUT_REG = 0 and OUT_REG = 1).

Source files
------------

// File: rtl/sram_1r1w_init.sv
// 1R1W word-addressed SRAM with byte strobes, write-first forwarding,
// selectable 1/2-cycle read latency and a hardware fill engine.
module sram_1r1w_init #(
  parameter int unsigned        DATA_W        = 32,
  parameter int unsigned        ADDR_W        = 14,
  parameter int unsigned        OUT_REG       = 0,
  parameter int unsigned        INIT_ON_RESET = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL      = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init_req,
  output logic                  busy,
  input  logic                  wcs,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [DATA_W/8-1:0]   wbyte,
  input  logic [DATA_W-1:0]     wdi,
  input  logic                  rcs,
  input  logic [ADDR_W-1:0]     ra,
  output logic [DATA_W-1:0]     rdo,
  output logic                  rvalid
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, INIT} state_t;
  localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? INIT : IDLE;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_go;
  logic                rd_go;
  logic [DATA_W-1:0]   rd_word;
  logic                src_vld;
  logic [DATA_W-1:0]   src_data;

  assign busy = (state == INIT);

  // init_req wins over a same-cycle access; a same-address write is forwarded per byte
  always_comb begin
    wr_go   = (state == IDLE) && !init_req && wcs;
    rd_go   = (state == IDLE) && !init_req && rcs;
    rd_word = mem[ra];
    for (int unsigned i = 0; i < NB; i++) begin
      if (wr_go && (wa == ra) && wbyte[i]) begin
        rd_word[8*i +: 8] = wdi[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_req) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        INIT: begin
          // the final address is written on this edge before leaving INIT
          if (cnt == '1) begin
            state <= IDLE;
          end
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // array has no reset; writes are suppressed while rstn is low
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (state == INIT) begin
        mem[cnt] <= INIT_VAL;
      end else if (wr_go) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (wbyte[i]) begin
            mem[wa][8*i +: 8] <= wdi[8*i +: 8];
          end
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              stage_vld;
      logic [DATA_W-1:0] stage_data;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          stage_vld  <= 1'b0;
          stage_data <= '0;
        end else begin
          stage_vld <= rd_go;
          if (rd_go) begin
            stage_data <= rd_word;
          end
        end
      end

      assign src_vld  = stage_vld;
      assign src_data = stage_data;
    end else begin : g_noreg
      assign src_vld  = rd_go;
      assign src_data = rd_word;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid <= 1'b0;
      rdo    <= '0;
    end else begin
      rvalid <= src_vld;
      if (src_vld) begin
        rdo <= src_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_1r1w_init.sv
module tb_sram_1r1w_init;

  localparam logic [31:0] IV = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        init_req;
  logic        wcs;
  logic [3:0]  wa;
  logic [3:0]  wbyte;
  logic [31:0] wdi;
  logic        rcs;
  logic [3:0]  ra;
  logic        busy0, busy1, rvalid0, rvalid1;
  logic [31:0] rdo0, rdo1;

  always #5 clk = ~clk;

  sram_1r1w_init #(
    .DATA_W(32), .ADDR_W(4), .OUT_REG(0), .INIT_ON_RESET(1), .INIT_VAL(IV)
  ) u_dut0 (
    .clk(clk), .rstn(rstn), .init_req(init_req), .busy(busy0),
    .wcs(wcs), .wa(wa), .wbyte(wbyte), .wdi(wdi),
    .rcs(rcs), .ra(ra), .rdo(rdo0), .rvalid(rvalid0)
  );

  sram_1r1w_init #(
    .DATA_W(32), .ADDR_W(4), .OUT_REG(1), .INIT_ON_RESET(1), .INIT_VAL(IV)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .init_req(init_req), .busy(busy1),
    .wcs(wcs), .wa(wa), .wbyte(wbyte), .wdi(wdi),
    .rcs(rcs), .ra(ra), .rdo(rdo1), .rvalid(rvalid1)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        wcs;
    logic [3:0]  wa;
    logic [3:0]  wbyte;
    logic [31:0] wdi;
    logic        rcs;
    logic [3:0]  ra;
    logic [31:0] exp;
  } vec_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last0, last1;
  logic [31:0] mem_m [16];
  bit          m_init;
  int          m_cnt;
  int          cyc;
  int          checks;
  int          errors;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_check();
    if (q0.size() > 0 && q0[0].due == cyc) begin
      chk("rvalid0", 32'(rvalid0), 32'd1);
      chk("rdo0", rdo0, q0[0].data);
      last0 = q0[0].data;
      void'(q0.pop_front());
    end else begin
      chk("rvalid0_idle", 32'(rvalid0), 32'd0);
      chk("rdo0_hold", rdo0, last0);
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      chk("rvalid1", 32'(rvalid1), 32'd1);
      chk("rdo1", rdo1, q1[0].data);
      last1 = q1[0].data;
      void'(q1.pop_front());
    end else begin
      chk("rvalid1_idle", 32'(rvalid1), 32'd0);
      chk("rdo1_hold", rdo1, last1);
    end
    chk("busy0", 32'(busy0), 32'(m_init));
    chk("busy1", 32'(busy1), 32'(m_init));
  endtask

  // Applies the currently driven inputs to the model for the coming edge,
  // advances one clock and checks outputs on the falling edge.
  task automatic step(input bit ovr = 1'b0, input logic [31:0] ovr_d = '0);
    logic [31:0] d;
    bit          acc;
    if (rstn) begin
      acc = !m_init && !init_req;
      if (acc && rcs) begin
        d = mem_m[ra];
        if (wcs && wa == ra) begin
          for (int b = 0; b < 4; b++) begin
            if (wbyte[b]) d[8*b +: 8] = wdi[8*b +: 8];
          end
        end
        if (ovr) d = ovr_d;
        q0.push_back('{d, cyc + 1});
        q1.push_back('{d, cyc + 2});
      end
      if (acc && wcs) begin
        for (int b = 0; b < 4; b++) begin
          if (wbyte[b]) mem_m[wa][8*b +: 8] = wdi[8*b +: 8];
        end
      end
      if (m_init) begin
        mem_m[m_cnt] = IV;
        if (m_cnt == 15) m_init = 1'b0;
        else m_cnt++;
      end else if (init_req) begin
        m_init = 1'b1;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    sb_check();
  endtask

  task automatic idle_inputs();
    init_req = 1'b0;
    wcs      = 1'b0;
    rcs      = 1'b0;
    wa       = '0;
    ra       = '0;
    wbyte    = '0;
    wdi      = '0;
  endtask

  task automatic apply_reset(input int n);
    idle_inputs();
    rstn = 1'b0;
    q0.delete();
    q1.delete();
    last0  = '0;
    last1  = '0;
    m_init = 1'b1;
    m_cnt  = 0;
    #1;
    chk("rst_busy0", 32'(busy0), 32'd1);
    chk("rst_busy1", 32'(busy1), 32'd1);
    chk("rst_rdo0", rdo0, 32'd0);
    chk("rst_rdo1", rdo1, 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    repeat (n) step();
    rstn = 1'b1;
  endtask

  task automatic wait_fill(input string name);
    int n;
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      step();
    end
    chk(name, 32'(n), 32'd16);
  endtask

  task automatic drain();
    idle_inputs();
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = 'x;

    tbl[0] = '{1'b1, 4'd3, 4'b0101, 32'h1122_3344, 1'b0, 4'd0, 32'h0};
    tbl[1] = '{1'b0, 4'd0, 4'b0000, 32'h0,         1'b1, 4'd3, 32'hA522_A544};
    tbl[2] = '{1'b1, 4'd7, 4'b1100, 32'hDEAD_BEEF, 1'b1, 4'd7, 32'hDEAD_A5A5};
    tbl[3] = '{1'b1, 4'd8, 4'b1111, 32'h1234_5678, 1'b1, 4'd9, 32'hA5A5_A5A5};
    tbl[4] = '{1'b0, 4'd0, 4'b0000, 32'h0,         1'b1, 4'd8, 32'h1234_5678};
    tbl[5] = '{1'b1, 4'd5, 4'b0000, 32'hFFFF_FFFF, 1'b1, 4'd5, 32'hA5A5_A5A5};
    tbl[6] = '{1'b1, 4'd9, 4'b1111, 32'h0000_0000, 1'b1, 4'd3, 32'hA522_A544};
    tbl[7] = '{1'b0, 4'd0, 4'b0000, 32'h0,         1'b1, 4'd9, 32'h0000_0000};

    idle_inputs();
    rstn = 1'b1;
    #1;

    // reset release starts a 16-cycle fill, then read back the pattern
    apply_reset(3);
    wait_fill("fill_after_reset");
    for (int i = 0; i < 16; i++) begin
      rcs = 1'b1;
      ra  = 4'(i);
      step();
    end
    drain();

    // strobes, forwarding, independent ports, read-after-write
    for (int i = 0; i < 8; i++) begin
      wcs   = tbl[i].wcs;
      wa    = tbl[i].wa;
      wbyte = tbl[i].wbyte;
      wdi   = tbl[i].wdi;
      rcs   = tbl[i].rcs;
      ra    = tbl[i].ra;
      step(1'b1, tbl[i].exp);
    end
    drain();

    // read in flight, then init_req with a dropped write, reads during busy
    rcs = 1'b1;
    ra  = 4'd3;
    step();
    idle_inputs();
    init_req = 1'b1;
    wcs      = 1'b1;
    wa       = 4'd1;
    wbyte    = 4'b1111;
    wdi      = 32'h0;
    rcs      = 1'b1;
    ra       = 4'd3;
    step();
    idle_inputs();
    init_req = 1'b1;
    rcs      = 1'b1;
    ra       = 4'd1;
    wait_fill("fill_on_request");
    idle_inputs();
    rcs = 1'b1;
    ra  = 4'd1;
    step(1'b1, IV);
    drain();

    // reset in the middle of a fill restarts it from address 0
    init_req = 1'b1;
    step();
    idle_inputs();
    repeat (5) step();
    apply_reset(3);
    wait_fill("fill_after_abort");

    // mem[i] = i, then sixteen back-to-back reads
    for (int i = 0; i < 16; i++) begin
      wcs   = 1'b1;
      wa    = 4'(i);
      wbyte = 4'b1111;
      wdi   = 32'(i);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      rcs = 1'b1;
      ra  = 4'(i);
      step(1'b1, 32'(i));
    end
    drain();

    chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
